uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10416 (12 bit periods at 868 clks/bit), watchdog limit.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  4  per-requester byte-pending flag, level-held until accepted.
REQ-006 SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 SHALL have port req_ack  output  4  one-cycle pulse, byte of requester i accepted.
REQ-008 SHALL have port req_done  output  4  one-cycle pulse, byte of requester i fully transmitted.
REQ-009 SHALL have port tx_data  output  8  byte to transmitter.
REQ-010 SHALL have port tx_valid  output  1  one-cycle start strobe to transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port tx_done  input  1  transmitter end-of-frame pulse.
REQ-013 SHALL have port grant_id  output  2  index of requester currently owning the transmitter.
REQ-014 SHALL have port arb_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog expiry (tied 0 when feature is compiled out).

Function
REQ-016 SHALL implement FSM IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-017 IDLE: if any req_valid is set and tx_busy=0, SHALL pick the winner, latch its byte into tx_data, set grant_id, pulse req_ack[winner], and go to LAUNCH next cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr (2 bits, wraps 3->0); after a grant to i, ptr=i+1 mod 4.
REQ-019 LAUNCH: tx_valid=1 for exactly one cycle; SHALL then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: on tx_busy=1 SHALL go to WAIT_DONE; tx_valid stays 0.
REQ-021 WAIT_DONE: on tx_done=1 SHALL pulse req_done[grant_id] in the same cycle as the registered output of the next edge (1-cycle latency), then return to IDLE.
REQ-022 tx_done seen during WAIT_BUSY (busy pulse missed) SHALL be treated as completion: req_done pulses and the FSM goes to IDLE.
REQ-023 tx_data and grant_id SHALL hold stable from LAUNCH until the return to IDLE.
REQ-024 req_valid changes for non-granted requesters during a transfer SHALL have no effect until IDLE.
REQ-025 In IDLE with tx_busy=1 (transmitter externally occupied), SHALL NOT grant.
REQ-026 Simultaneous requests: the winner SHALL be the first set bit at or after ptr; all others wait. No requester SHALL wait more than 3 transfers.
REQ-027 Minimum gap: back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, ptr=0, tx_valid=0, tx_data=0, grant_id=0, req_ack=0, req_done=0, arb_busy=0, timeout_err=0, watchdog=0.
REQ-029 Reset mid-transfer SHALL abort without req_done; the requester keeps req_valid and is re-arbitrated after release.
REQ-030 Deassertion SHALL take effect on the first posedge clk after rst_n goes high.

Configuration
REQ-031 Macro UART_TX_ARBITER_TIMEOUT_EN, when defined, SHALL compile in a 16-bit watchdog counting cycles in WAIT_BUSY and WAIT_DONE, cleared on entry to LAUNCH.
REQ-032 With the macro defined, reaching TIMEOUT_CYCLES SHALL pulse timeout_err for 1 cycle, return the FSM to IDLE, advance ptr as for a normal grant, and suppress req_done.
REQ-033 Without the macro, SHALL have no watchdog, timeout_err=0 constantly, and an indefinite wait for tx_done.

Verification
REQ-034 Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, model transmitter -> req_ack[0] 1 cycle, tx_valid 1 cycle with tx_data=8'hA5, req_done[0] after tx_done, arb_busy low afterwards.
REQ-035 All four requesters held valid with bytes 8'h10,8'h11,8'h12,8'h13 -> grant order 0,1,2,3,0 (ptr wrap); each req_done in order.
REQ-036 Requester 2 valid while a transfer for 0 is in flight -> no tx_valid until after req_done[0]; requester 2 is then granted.
REQ-037 rst_n low during WAIT_DONE -> all outputs 0 immediately (no clk edge); no req_done; requester re-granted after release.
REQ-038 Macro defined, transmitter never asserts tx_done -> timeout_err pulse exactly TIMEOUT_CYCLES cycles after LAUNCH, FSM in IDLE, no req_done.
REQ-039 tx_busy=1 held in IDLE with req_valid=4'b1000 -> no req_ack until tx_busy=0, then grant to requester 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Define UART_TX_ARBITER_TIMEOUT_EN to compile in the transfer watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10416
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [1:0]           grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] win;
  logic       found;

  // First requester at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign arb_busy = (state_q != StIdle);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  // Expiry lands exactly TIMEOUT_CYCLES cycles after the LAUNCH cycle.
  localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 2);
  logic [15:0] wd_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'd0;
      grant_id    <= 2'd0;
      req_ack     <= '0;
      req_done    <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      timeout_err <= 1'b0;
      wd_q        <= 16'd0;
`endif
    end else begin
      req_ack     <= '0;
      req_done    <= '0;
      tx_valid    <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (found && !tx_busy) begin
            state_q  <= StLaunch;
            tx_data  <= req_data[{win, 3'b000} +: 8];
            grant_id <= win;
            req_ack  <= NUM_REQ'(1) << win;
            tx_valid <= 1'b1;
            ptr_q    <= win + 2'd1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            wd_q     <= 16'd0;
`endif
          end
        end
        StLaunch: state_q <= StWaitBusy;
        StWaitBusy, StWaitDone: begin
          // A completion seen before busy means the busy pulse was missed.
          if (tx_done) begin
            state_q  <= StIdle;
            req_done <= NUM_REQ'(1) << grant_id;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          end else if (wd_q == WdLast) begin
            state_q     <= StIdle;
            timeout_err <= 1'b1;
`endif
          end else begin
            if (state_q == StWaitBusy && tx_busy) state_q <= StWaitDone;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            wd_q <= wd_q + 16'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a hand-driven transmitter.
module tb_uart_tx_arbiter;

  localparam int unsigned Timeout = 20;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  req_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int checks;
  int failures;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .req_done    (req_done),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {req_ack, req_done, tx_valid, grant_id, arb_busy, timeout_err}, 32'd0);
    check({tag, "_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  // Waits for the launch, checks the grant, then plays one frame on the transmitter.
  task automatic xmit(input int idx, input logic [7:0] b, input int exp_lat, input int late_idx);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_valid && lat < 20);
    check("grant_latency", lat, exp_lat);
    check("ack", {28'd0, req_ack}, 32'd1 << idx);
    check("tx_data", {24'd0, tx_data}, {24'd0, b});
    check("grant_id", {30'd0, grant_id}, idx);
    check("arb_busy_launch", {31'd0, arb_busy}, 32'd1);
    req_valid[idx] = 1'b0;
    if (late_idx >= 0) req_valid[late_idx] = 1'b1;
    @(negedge clk);
    check("tx_valid_one_cycle", {30'd0, tx_valid, req_ack[idx]}, 32'd0);
    tx_busy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("in_flight_quiet", {31'd0, tx_valid}, 32'd0);
    end
    check("tx_data_hold", {22'd0, grant_id, tx_data}, {22'd0, 2'(idx), b});
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("req_done", {28'd0, req_done}, 32'd1 << idx);
    check("idle_after_done", {30'd0, arb_busy, timeout_err}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 4'd0;
    req_data  = 32'd0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All four pending; requester 0 re-requests mid-round to show pointer wrap.
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    xmit(0, 8'h10, 1, -1);
    xmit(1, 8'h11, 1, 0);
    xmit(2, 8'h12, 1, -1);
    xmit(3, 8'h13, 1, -1);
    xmit(0, 8'h10, 1, -1);

    // Requester 2 arrives while 0 is in flight: no launch until 0 completes.
    req_data  = 32'h0022_0020;
    req_valid = 4'b0001;
    xmit(0, 8'h20, 1, 2);
    xmit(2, 8'h22, 1, -1);

    // Transmitter externally busy in idle: hold off the grant.
    req_data  = 32'h3300_0000;
    req_valid = 4'b1000;
    tx_busy   = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_hold_ack", {28'd0, req_ack}, 32'd0);
    check("busy_hold_arb", {31'd0, arb_busy}, 32'd0);
    tx_busy = 1'b0;
    xmit(3, 8'h33, 1, -1);

    // Reset while waiting for tx_done aborts silently; requester is re-granted.
    req_data  = 32'h0000_4400;
    req_valid = 4'b0010;
    @(negedge clk);
    check("pre_reset_launch", {31'd0, tx_valid}, 32'd1);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, arb_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    rst_n   = 1'b1;
    check("no_done_after_abort", {28'd0, req_done}, 32'd0);
    xmit(1, 8'h44, 1, -1);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // Transmitter never responds: watchdog fires Timeout cycles after launch.
    req_data  = 32'h0055_0000;
    req_valid = 4'b0100;
    @(negedge clk);
    check("wd_launch", {31'd0, tx_valid}, 32'd1);
    req_valid = 4'b0000;
    repeat (Timeout - 1) @(negedge clk);
    check("wd_before", {30'd0, timeout_err, arb_busy}, 32'd1);
    @(negedge clk);
    check("wd_pulse", {31'd0, timeout_err}, 32'd1);
    check("wd_idle", {31'd0, arb_busy}, 32'd0);
    check("wd_no_done", {28'd0, req_done}, 32'd0);
    @(negedge clk);
    check("wd_pulse_end", {31'd0, timeout_err}, 32'd0);
`else
    // Without the watchdog, a stalled frame waits indefinitely.
    req_data  = 32'h0055_0000;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (Timeout + 10) @(negedge clk);
    check("no_wd_still_busy", {30'd0, timeout_err, arb_busy}, 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("no_wd_done", {28'd0, req_done}, 32'b0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
